uart_transceiver: RTL and testbench

- Single-clock full-duplex UART with an independent transmit path and receive path sharing one clock and one reset.
- TX serialises a PAYLOAD_BITS word as 8N1-style framing on request: start bit, LSB-first data, one stop bit.
- RX deserialises an asynchronous serial line into a word and flags completion.
- Sits between a parallel host interface and an external serial pin pair.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_bit_timer.sv | 27 ++
 rtl/uart_transceiver.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_transceiver.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helper functions for the UART transceiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  // Clocks per bit, integer division.
  function automatic int unsigned calc_cpb(input int unsigned clk_freq,
                                           input int unsigned bit_rate);
    return clk_freq / bit_rate;
  endfunction

  // Half a bit period, used to land the start-bit check mid-bit.
  function automatic int unsigned calc_half(input int unsigned clk_freq,
                                            input int unsigned bit_rate);
    return calc_cpb(clk_freq, bit_rate) / 2;
  endfunction

  // Counter width able to hold values 0..n-1, never narrower than one bit.
  function automatic int unsigned calc_cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; terminal count is flagged while the count sits at zero.
module uart_bit_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic             o_tc_c
);

  logic [CNT_W-1:0] r_count;

  // Load has priority; otherwise count down and hold at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_tc_c = (r_count == '0);

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1-style UART: independent TX and RX paths on one clock.
// Requires at least 2 clocks per bit and at least 2 payload bits.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned BIT_RATE     = 115200,
  parameter int unsigned CLK_FREQ     = 16_000_000,
  parameter int unsigned PAYLOAD_BITS = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    io_i_tx_trig,
  input  logic [PAYLOAD_BITS-1:0] io_i_data,
  output logic                    io_o_tx_busy,
  output logic                    io_o_tx_done,
  output logic                    io_o_serial_data,
  input  logic                    io_i_serial_data,
  output logic                    io_o_rx_done,
  output logic [PAYLOAD_BITS-1:0] io_o_data
);

  localparam int unsigned CPB   = calc_cpb(CLK_FREQ, BIT_RATE);
  localparam int unsigned HALF  = calc_half(CLK_FREQ, BIT_RATE);
  localparam int unsigned CNT_W = calc_cnt_w(CPB);
  localparam int unsigned IDX_W = calc_cnt_w(PAYLOAD_BITS);

  localparam logic [CNT_W-1:0] CPB_LD  = CNT_W'(CPB - 1);
  // STOP holds at zero for one extra cycle so tx_done can be registered.
  localparam logic [CNT_W-1:0] STOP_LD = CNT_W'(CPB - 2);
  localparam logic [CNT_W-1:0] HALF_LD = CNT_W'((HALF > 0) ? HALF - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAYLOAD_BITS - 1);

  // ---------------- TX path ----------------
  uart_state_t             r_tx_state;
  logic [PAYLOAD_BITS-1:0] r_tx_shift;
  logic [IDX_W-1:0]        r_tx_idx;
  logic                    r_tx_busy;
  logic                    r_tx_done;
  logic                    r_tx_line;
  logic                    w_tx_tc;
  logic                    w_tx_load;
  logic [CNT_W-1:0]        w_tx_load_val;

  uart_bit_timer #(.CNT_W(CNT_W)) u_tx_timer (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_tx_load),
    .i_load_val (w_tx_load_val),
    .o_tc_c     (w_tx_tc)
  );

  // TX timer reload at each bit boundary.
  always_comb begin
    w_tx_load     = 1'b0;
    w_tx_load_val = CPB_LD;
    case (r_tx_state)
      IDLE:    w_tx_load = io_i_tx_trig;
      START:   w_tx_load = w_tx_tc;
      DATA: begin
        w_tx_load = w_tx_tc;
        if (r_tx_idx == LAST_IDX) w_tx_load_val = STOP_LD;
      end
      default: w_tx_load = 1'b0;
    endcase
  end

  // TX frame sequencer with registered line, busy and done.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_state <= IDLE;
      r_tx_shift <= '0;
      r_tx_idx   <= '0;
      r_tx_busy  <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx_line  <= 1'b1;
    end else begin
      r_tx_done <= 1'b0;
      case (r_tx_state)
        IDLE: begin
          if (io_i_tx_trig) begin
            r_tx_shift <= io_i_data;
            r_tx_busy  <= 1'b1;
            r_tx_line  <= 1'b0;
            r_tx_state <= START;
          end
        end
        START: begin
          if (w_tx_tc) begin
            r_tx_line  <= r_tx_shift[0];
            r_tx_idx   <= '0;
            r_tx_state <= DATA;
          end
        end
        DATA: begin
          if (w_tx_tc) begin
            if (r_tx_idx == LAST_IDX) begin
              r_tx_line  <= 1'b1;
              r_tx_state <= STOP;
            end else begin
              r_tx_line  <= r_tx_shift[1];
              r_tx_shift <= r_tx_shift >> 1;
              r_tx_idx   <= r_tx_idx + IDX_W'(1);
            end
          end
        end
        STOP: begin
          if (w_tx_tc) begin
            if (r_tx_done) begin
              r_tx_busy  <= 1'b0;
              r_tx_state <= IDLE;
            end else begin
              r_tx_done <= 1'b1;
            end
          end
        end
        default: r_tx_state <= IDLE;
      endcase
    end
  end

  assign io_o_tx_busy     = r_tx_busy;
  assign io_o_tx_done     = r_tx_done;
  assign io_o_serial_data = r_tx_line;

  // ---------------- RX path ----------------
  uart_state_t             r_rx_state;
  logic                    r_sync1;
  logic                    r_sync2;
  logic                    r_sync_prev;
  logic [PAYLOAD_BITS-1:0] r_rx_shift;
  logic [IDX_W-1:0]        r_rx_idx;
  logic                    r_rx_done;
  logic [PAYLOAD_BITS-1:0] r_rx_data;
  logic                    w_rx_fall;
  logic                    w_rx_tc;
  logic                    w_rx_load;
  logic [CNT_W-1:0]        w_rx_load_val;

  // Two-flop synchronizer plus a delayed copy for falling-edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_prev <= 1'b1;
    end else begin
      r_sync1     <= io_i_serial_data;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  assign w_rx_fall = r_sync_prev & ~r_sync2;

  uart_bit_timer #(.CNT_W(CNT_W)) u_rx_timer (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_rx_load),
    .i_load_val (w_rx_load_val),
    .o_tc_c     (w_rx_tc)
  );

  // RX timer: half a bit to the start-bit centre, then whole bits.
  always_comb begin
    w_rx_load     = 1'b0;
    w_rx_load_val = CPB_LD;
    case (r_rx_state)
      IDLE: begin
        w_rx_load     = w_rx_fall;
        w_rx_load_val = HALF_LD;
      end
      START:   w_rx_load = w_rx_tc & ~r_sync2;
      DATA:    w_rx_load = w_rx_tc;
      default: w_rx_load = 1'b0;
    endcase
  end

  // RX frame sampler; only a frame with a high stop bit updates the output word.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_state <= IDLE;
      r_rx_shift <= '0;
      r_rx_idx   <= '0;
      r_rx_done  <= 1'b0;
      r_rx_data  <= '0;
    end else begin
      r_rx_done <= 1'b0;
      case (r_rx_state)
        IDLE: begin
          if (w_rx_fall) r_rx_state <= START;
        end
        START: begin
          if (w_rx_tc) begin
            r_rx_idx   <= '0;
            r_rx_state <= r_sync2 ? IDLE : DATA;
          end
        end
        DATA: begin
          if (w_rx_tc) begin
            r_rx_shift <= {r_sync2, r_rx_shift[PAYLOAD_BITS-1:1]};
            if (r_rx_idx == LAST_IDX) begin
              r_rx_state <= STOP;
            end else begin
              r_rx_idx <= r_rx_idx + IDX_W'(1);
            end
          end
        end
        STOP: begin
          if (w_rx_tc) begin
            if (r_sync2) begin
              r_rx_data <= r_rx_shift;
              r_rx_done <= 1'b1;
            end
            r_rx_state <= IDLE;
          end
        end
        default: r_rx_state <= IDLE;
      endcase
    end
  end

  assign io_o_rx_done = r_rx_done;
  assign io_o_data    = r_rx_data;

endmodule

// File: tb/tb_uart_transceiver.sv
// Bench for uart_transceiver: frame-position model for TX, expected-word queue for RX.
`timescale 1ns/1ps
module tb_uart_transceiver;

  localparam int unsigned CPB   = 138;
  localparam int unsigned PB    = 8;
  localparam int unsigned FRAME = (PB + 2) * CPB;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       trig = 1'b0;
  logic [7:0] din  = 8'h00;
  logic       loop = 1'b1;
  logic       drv  = 1'b1;
  logic       busy, done, txl, rx_done, rx_in;
  logic [7:0] dout;

  int total = 0;
  int bad   = 0;

  assign rx_in = loop ? txl : drv;

  uart_transceiver #(
    .BIT_RATE     (115200),
    .CLK_FREQ     (16_000_000),
    .PAYLOAD_BITS (8)
  ) dut (
    .clock            (clk),
    .reset            (rst),
    .io_i_tx_trig     (trig),
    .io_i_data        (din),
    .io_o_tx_busy     (busy),
    .io_o_tx_done     (done),
    .io_o_serial_data (txl),
    .io_i_serial_data (rx_in),
    .io_o_rx_done     (rx_done),
    .io_o_data        (dout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected TX line from the position inside a frame.
  function automatic logic line_at(input int pos, input logic [7:0] w);
    int b;
    b = pos / CPB;
    if (b == 0) return 1'b0;
    if (b <= PB) return w[b-1];
    return 1'b1;
  endfunction

  // Model state
  bit         m_busy = 0;
  int         m_pos  = 0;
  logic [7:0] m_word = 8'h00;
  logic       exp_line = 1'b1;
  logic       exp_busy = 1'b0;
  logic       exp_done = 1'b0;
  logic [7:0] rxq[$];
  logic [7:0] m_rx_word = 8'h00;
  int         rx_cnt = 0;

  // Model advances on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    if (rst) begin
      m_busy = 0;
      m_pos  = 0;
      rxq.delete();
      m_rx_word = 8'h00;
    end else if (!m_busy) begin
      if (trig) begin
        m_busy = 1;
        m_pos  = 0;
        m_word = din;
        if (loop) rxq.push_back(din);
      end
    end else begin
      m_pos++;
      if (m_pos == FRAME) m_busy = 0;
    end
    exp_busy = m_busy;
    exp_done = m_busy && (m_pos == FRAME - 1);
    exp_line = m_busy ? line_at(m_pos, m_word) : 1'b1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [7:0] e;
    chk("tx_line", 32'(txl), 32'(exp_line));
    chk("tx_busy", 32'(busy), 32'(exp_busy));
    chk("tx_done", 32'(done), 32'(exp_done));
    if (rx_done === 1'b1) begin
      rx_cnt++;
      if (rxq.size() == 0) begin
        chk("rx_done_unexpected", 32'(rx_done), 32'd0);
      end else begin
        e = rxq.pop_front();
        chk("rx_word", 32'(dout), 32'(e));
        m_rx_word = e;
      end
    end else begin
      chk("rx_hold", 32'(dout), 32'(m_rx_word));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Trigger one frame and measure it until busy falls (bounded).
  task automatic send(input logic [7:0] b, output int busy_cyc, output int done_pos,
                      output int done_cnt, output logic [9:0] mids);
    bit fin;
    @(posedge clk); #1; din = b; trig = 1'b1;
    @(posedge clk); #1; trig = 1'b0;
    busy_cyc = 0; done_pos = -1; done_cnt = 0; mids = '1; fin = 0;
    for (int k = 0; k < int'(FRAME) + 100 && !fin; k++) begin
      @(negedge clk);
      if (busy !== 1'b1) begin
        fin = 1;
      end else begin
        if (done === 1'b1) begin
          done_pos = busy_cyc;
          done_cnt++;
        end
        if ((busy_cyc % CPB) == CPB / 2 && (busy_cyc / CPB) < 10)
          mids[busy_cyc / CPB] = txl;
        busy_cyc++;
      end
    end
    if (!fin) chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic wait_idle(input int n);
    bit fin;
    fin = 0;
    for (int k = 0; k < n && !fin; k++) begin
      @(negedge clk);
      if (busy === 1'b0) fin = 1;
    end
    if (!fin) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Bench-driven serial frame on the RX input.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    drv = 1'b0; cyc(CPB);
    for (int i = 0; i < 8; i++) begin
      drv = b[i]; cyc(CPB);
    end
    drv = stop_bit; cyc(CPB);
    drv = 1'b1; cyc(3 * CPB);
  endtask

  initial begin
    int bc, dp, dc;
    logic [9:0] mv;

    // Reset values
    cyc(3);
    @(negedge clk);
    chk("rst_line", 32'(txl), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx_done", 32'(rx_done), 32'd0);
    chk("rst_odata", 32'(dout), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    cyc(5);

    // Loopback: three frames back-to-back
    send(8'hAB, bc, dp, dc, mv); chk("len_AB", 32'(bc), 32'd1380);
    send(8'hCD, bc, dp, dc, mv); chk("len_CD", 32'(bc), 32'd1380);
    send(8'hEF, bc, dp, dc, mv); chk("len_EF", 32'(bc), 32'd1380);
    cyc(300);
    chk("rx_cnt_3", 32'(rx_cnt), 32'd3);
    chk("rx_last_EF", 32'(dout), 32'hEF);

    // TX waveform for 0x01
    send(8'h01, bc, dp, dc, mv);
    chk("len_01", 32'(bc), 32'd1380);
    chk("done_pos_01", 32'(dp), 32'd1379);
    chk("done_cnt_01", 32'(dc), 32'd1);
    chk("wave_01", 32'(mv), 32'(10'b1000000010));
    cyc(300);
    chk("rx_01", 32'(dout), 32'h01);

    // Trigger while busy is ignored, data change after capture has no effect
    din = 8'hAA; trig = 1'b1; cyc(1); trig = 1'b0;
    cyc(500);
    din = 8'h55; trig = 1'b1; cyc(1); trig = 1'b0; din = 8'h00;
    wait_idle(2000);
    cyc(300);
    chk("no_second_frame", 32'(busy), 32'd0);
    chk("rx_cnt_AA", 32'(rx_cnt), 32'd5);
    chk("rx_AA", 32'(dout), 32'hAA);

    // RX glitch on the start bit
    loop = 1'b0; drv = 1'b1; cyc(10);
    drv = 1'b0; cyc(20); drv = 1'b1;
    cyc(2000);
    chk("glitch_cnt", 32'(rx_cnt), 32'd5);
    chk("glitch_hold", 32'(dout), 32'hAA);

    // Framing error, then a good frame
    drive_frame(8'h3C, 1'b0);
    chk("ferr_cnt", 32'(rx_cnt), 32'd5);
    chk("ferr_hold", 32'(dout), 32'hAA);
    rxq.push_back(8'h3C);
    drive_frame(8'h3C, 1'b1);
    chk("good_cnt", 32'(rx_cnt), 32'd6);
    chk("good_3C", 32'(dout), 32'h3C);

    // Reset in the middle of a TX data bit
    loop = 1'b1; cyc(5);
    din = 8'h96; trig = 1'b1; cyc(1); trig = 1'b0;
    cyc(3 * CPB + 40);
    rst = 1'b1; cyc(1);
    @(negedge clk);
    chk("mid_rst_line", 32'(txl), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_odata", 32'(dout), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    cyc(5);
    send(8'h5A, bc, dp, dc, mv);
    chk("len_5A", 32'(bc), 32'd1380);
    chk("wave_5A", 32'(mv), 32'(10'b1010110100));
    cyc(300);
    chk("rx_cnt_5A", 32'(rx_cnt), 32'd7);
    chk("rx_5A", 32'(dout), 32'h5A);

    cyc(10);
    chk("rxq_empty", 32'(rxq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
